imem_arbiter: RTL

- Shares the single-port Instruction Memory (IM) between two requesters: the fetch stage (read-only) and a program loader/debug port (read/write).
- Sits between IF, the loader and IM.
- Round-robin arbitration, plus burst locking for loader transfers.
- Produces `if_stall` so the fetch stage holds its PC while it does not own IM.

---
 rtl/imem_arbiter_if.sv | 36 +++
 rtl/imem_arbiter.sv | 71 +++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, loader and instruction-memory signals for the IM arbiter.
interface imem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_stall;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_last;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    logic              im_en;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;
    logic [DATA_W-1:0] im_rdata;

    modport slave (
        input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_last, im_rdata,
        output if_gnt, if_stall, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata,
               im_en, im_we, im_addr, im_wdata
    );
    modport master (
        output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, ld_last, im_rdata,
        input  if_gnt, if_stall, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata,
               im_en, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of single-port IM between fetch and loader, with loader burst lock.
module imem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 16
) (
    input logic          clk,
    input logic          reset,
    imem_arbiter_if.slave bus
);
    typedef enum logic {OPEN, LD_LOCK} state_t;

    state_t            state;
    logic              last_ld;
    logic              if_pend;
    logic              ld_pend;
    logic              if_gnt;
    logic              ld_gnt;
    logic [7:0]        beat_cnt;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] ld_hold;

    // last_ld=1 means the loader owned IM last, so fetch wins a tie
    always_comb begin
        if_gnt = !reset && state == OPEN && bus.if_req && (!bus.ld_req || last_ld);
        ld_gnt = !reset && bus.ld_req && (state == LD_LOCK || !bus.if_req || !last_ld);
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.ld_gnt    = ld_gnt;
    assign bus.if_stall  = bus.if_req && !if_gnt;
    assign bus.im_en     = if_gnt || ld_gnt;
    assign bus.im_we     = ld_gnt && bus.ld_we;
    assign bus.im_addr   = if_gnt ? {bus.if_addr[ADDR_W-1:2], 2'b00} :
                           ld_gnt ? {bus.ld_addr[ADDR_W-1:2], 2'b00} : '0;
    assign bus.im_wdata  = (if_gnt || ld_gnt) ? bus.ld_wdata : '0;
    assign bus.if_rvalid = if_pend && !reset;
    assign bus.ld_rvalid = ld_pend && !reset;
    assign bus.if_rdata  = bus.if_rvalid ? bus.im_rdata : if_hold;
    assign bus.ld_rdata  = bus.ld_rvalid ? bus.im_rdata : ld_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= OPEN;
            last_ld  <= 1'b1;
            beat_cnt <= '0;
            if_pend  <= 1'b0;
            ld_pend  <= 1'b0;
            if_hold  <= '0;
            ld_hold  <= '0;
        end else begin
            if_pend <= if_gnt;
            ld_pend <= ld_gnt && !bus.ld_we;
            if (if_pend) if_hold <= bus.im_rdata;
            if (ld_pend) ld_hold <= bus.im_rdata;
            if (if_gnt) last_ld <= 1'b0;
            else if (ld_gnt) last_ld <= 1'b1;
            if (state == OPEN) begin
                if (ld_gnt && !bus.ld_last && BURST_MAX > 1) begin
                    state    <= LD_LOCK;
                    beat_cnt <= 8'd1;
                end
            end else if (!bus.ld_req || bus.ld_last || beat_cnt == 8'(BURST_MAX - 1)) begin
                state    <= OPEN;
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end
endmodule
